// File: rtl/xor_parity_accumulator.sv
// Parity generator/checker: reduces each WIDTH-bit beat to one bit and XOR-accumulates
// across an in_last-delimited packet, with even/odd mode, optional compare and beat count.
module xor_parity_accumulator #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             mode_odd,
    input  logic             chk_en,
    input  logic             chk_parity,
    output logic             out_valid,
    output logic             out_parity,
    output logic             out_err,
    output logic             busy,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, ACC} state_t;

    state_t           state;
    logic             acc;
    logic [CNT_W-1:0] cnt;
    logic             sat;

    logic             word_par;
    logic             acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             sat_next;
    logic             par_final;

    // In IDLE the incoming beat starts a fresh packet, so prior acc/cnt/sat are ignored.
    always_comb begin
        word_par = ^in_data;
        acc_next = word_par;
        cnt_next = CNT_W'(1);
        if (state == ACC) begin
            acc_next = acc ^ word_par;
            cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        end
        sat_next  = ((state == ACC) && sat) || (cnt_next == CNT_MAX);
        par_final = acc_next ^ mode_odd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= 1'b0;
            cnt        <= '0;
            sat        <= 1'b0;
            out_valid  <= 1'b0;
            out_parity <= 1'b0;
            out_err    <= 1'b0;
            busy       <= 1'b0;
            beat_cnt   <= '0;
            cnt_sat    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                if (in_last) begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    acc        <= 1'b0;
                    cnt        <= '0;
                    sat        <= 1'b0;
                    out_valid  <= 1'b1;
                    out_parity <= par_final;
                    out_err    <= chk_en && (par_final != chk_parity);
                    beat_cnt   <= cnt_next;
                    cnt_sat    <= sat_next;
                end else begin
                    state <= ACC;
                    busy  <= 1'b1;
                    acc   <= acc_next;
                    cnt   <= cnt_next;
                    sat   <= sat_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_xor_parity_accumulator.sv
// Bench for xor_parity_accumulator: directed scenarios plus randomized traffic against a
// packet-level model; a second instance with CNT_W=2 exercises counter saturation.
module tb_xor_parity_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_last;
    logic       mode_odd;
    logic       chk_en;
    logic       chk_parity;

    logic       out_valid, out_parity, out_err, busy, cnt_sat;
    logic [7:0] beat_cnt;
    logic       out_valid_s, out_parity_s, out_err_s, busy_s, cnt_sat_s;
    logic [1:0] beat_cnt_s;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    xor_parity_accumulator #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .mode_odd(mode_odd), .chk_en(chk_en), .chk_parity(chk_parity),
        .out_valid(out_valid), .out_parity(out_parity), .out_err(out_err),
        .busy(busy), .beat_cnt(beat_cnt), .cnt_sat(cnt_sat)
    );

    xor_parity_accumulator #(.WIDTH(4), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .mode_odd(mode_odd), .chk_en(chk_en), .chk_parity(chk_parity),
        .out_valid(out_valid_s), .out_parity(out_parity_s), .out_err(out_err_s),
        .busy(busy_s), .beat_cnt(beat_cnt_s), .cnt_sat(cnt_sat_s)
    );

    // Apply one cycle of inputs at the falling edge; on return the outputs reflect them.
    task automatic drive(input logic v, input logic [3:0] d, input logic l,
                         input logic mo, input logic ce, input logic cp);
        in_valid   = v;
        in_data    = d;
        in_last    = l;
        mode_odd   = mo;
        chk_en     = ce;
        chk_parity = cp;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; in_data = 0; in_last = 0; mode_odd = 0; chk_en = 0; chk_parity = 0;
        #12;
        tests++;
        if ({out_valid, out_parity, out_err, busy, beat_cnt, cnt_sat} !== 13'd0) begin
            fails++;
            $display("FAIL reset_state: got %b want 0", {out_valid, out_parity, out_err, busy, beat_cnt, cnt_sat});
        end
        tests++;
        if ({out_valid_s, out_parity_s, out_err_s, busy_s, beat_cnt_s, cnt_sat_s} !== 7'd0) begin
            fails++;
            $display("FAIL reset_state_s: got %b want 0", {out_valid_s, out_parity_s, out_err_s, busy_s, beat_cnt_s, cnt_sat_s});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_exhaustive_single();
        logic [3:0] w;
        logic       p;
        for (int i = 0; i < 16; i++) begin
            w = 4'(i);
            p = w[0] ^ w[1] ^ w[2] ^ w[3];
            drive(1, w, 1, 0, 0, 0);
            tests++;
            if ({out_valid, out_parity, out_err, busy, beat_cnt, cnt_sat} !== {1'b1, p, 1'b0, 1'b0, 8'd1, 1'b0}) begin
                fails++;
                $display("FAIL single_%0h: got v=%b p=%b e=%b busy=%b cnt=%0d sat=%b want v=1 p=%b e=0 busy=0 cnt=1 sat=0",
                         w, out_valid, out_parity, out_err, busy, beat_cnt, cnt_sat, p);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_pulse_end: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_multi_gap();
        logic [3:0] words [5] = '{4'h3, 4'h0, 4'h0, 4'h5, 4'h7};
        logic       vals  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(vals[i], words[i], (i == 1), 0, 0, 0);
            tests++;
            if ({busy, out_valid} !== 2'b10) begin
                fails++;
                $display("FAIL multi_busy_%0d: got busy=%b out_valid=%b want busy=1 out_valid=0", i, busy, out_valid);
            end
        end
        drive(vals[4], words[4], 1, 0, 0, 0);
        tests++;
        if ({out_valid, out_parity, busy, beat_cnt, cnt_sat} !== {1'b1, 1'b1, 1'b0, 8'd3, 1'b0}) begin
            fails++;
            $display("FAIL multi_done: got v=%b p=%b busy=%b cnt=%0d sat=%b want v=1 p=1 busy=0 cnt=3 sat=0",
                     out_valid, out_parity, busy, beat_cnt, cnt_sat);
        end
        drive(0, 0, 0, 0, 0, 0);
        tests++;
        if ({out_valid, out_parity, beat_cnt} !== {1'b0, 1'b1, 8'd3}) begin
            fails++;
            $display("FAIL multi_hold: got v=%b p=%b cnt=%0d want v=0 p=1 cnt=3", out_valid, out_parity, beat_cnt);
        end
    endtask

    task automatic test_odd_check();
        logic ce_t [3] = '{1'b1, 1'b1, 1'b0};
        logic cp_t [3] = '{1'b0, 1'b1, 1'b0};
        logic er_t [3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'hF, 1, 1, ce_t[i], cp_t[i]);
            tests++;
            if ({out_valid, out_parity, out_err} !== {1'b1, 1'b1, er_t[i]}) begin
                fails++;
                $display("FAIL odd_check_%0d: got v=%b p=%b err=%b want v=1 p=1 err=%b",
                         i, out_valid, out_parity, out_err, er_t[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] words [3] = '{4'h1, 4'h3, 4'h7};
        logic       par   [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive(1, words[i], 1, 0, 0, 0);
            tests++;
            if ({out_valid, out_parity} !== {1'b1, par[i]}) begin
                fails++;
                $display("FAIL b2b_%0d: got v=%b p=%b want v=1 p=%b", i, out_valid, out_parity, par[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        drive(1, 4'h3, 0, 0, 0, 0);
        drive(1, 4'h5, 0, 0, 0, 0);
        in_valid = 0;
        #3 rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, out_parity, out_err, busy, beat_cnt, cnt_sat} !== 13'd0) begin
            fails++;
            $display("FAIL async_reset: got %b want 0", {out_valid, out_parity, out_err, busy, beat_cnt, cnt_sat});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if ({out_valid, busy} !== 2'b00) begin
            fails++;
            $display("FAIL reset_no_valid: got v=%b busy=%b want 0 0", out_valid, busy);
        end
        drive(1, 4'h8, 1, 0, 0, 0);
        tests++;
        if ({out_valid, out_parity, beat_cnt} !== {1'b1, 1'b1, 8'd1}) begin
            fails++;
            $display("FAIL after_reset: got v=%b p=%b cnt=%0d want v=1 p=1 cnt=1", out_valid, out_parity, beat_cnt);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) drive(1, 4'h1, (i == 4), 0, 0, 0);
        tests++;
        if ({out_valid_s, out_parity_s, beat_cnt_s, cnt_sat_s} !== {1'b1, 1'b1, 2'd3, 1'b1}) begin
            fails++;
            $display("FAIL sat_5beats: got v=%b p=%b cnt=%0d sat=%b want v=1 p=1 cnt=3 sat=1",
                     out_valid_s, out_parity_s, beat_cnt_s, cnt_sat_s);
        end
        tests++;
        if ({beat_cnt, cnt_sat} !== {8'd5, 1'b0}) begin
            fails++;
            $display("FAIL wide_5beats: got cnt=%0d sat=%b want cnt=5 sat=0", beat_cnt, cnt_sat);
        end
        drive(1, 4'h1, 0, 0, 0, 0);
        drive(1, 4'h1, 1, 0, 0, 0);
        tests++;
        if ({out_valid_s, out_parity_s, beat_cnt_s, cnt_sat_s} !== {1'b1, 1'b0, 2'd2, 1'b0}) begin
            fails++;
            $display("FAIL sat_clear: got v=%b p=%b cnt=%0d sat=%b want v=1 p=0 cnt=2 sat=0",
                     out_valid_s, out_parity_s, beat_cnt_s, cnt_sat_s);
        end
    endtask

    // Reference: collect the packet's words, then reduce every bit of every word at the end.
    task automatic test_random();
        logic [3:0] pkt [$];
        logic v, l, mo, ce, cp, ev, ep, ee;
        logic [3:0] d;
        int n;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v  = ($urandom_range(0, 9) < 7);
            l  = ($urandom_range(0, 9) < 3);
            d  = 4'($urandom_range(0, 15));
            mo = 1'($urandom); ce = 1'($urandom); cp = 1'($urandom);
            ev = 0; ep = 0; ee = 0; n = 0;
            if (v) begin
                pkt.push_back(d);
                if (l) begin
                    n = pkt.size();
                    foreach (pkt[k]) for (int b = 0; b < 4; b++) ep ^= pkt[k][b];
                    ep ^= mo;
                    ee = ce && (ep != cp);
                    ev = 1;
                    pkt.delete();
                end
            end
            drive(v, d, l, mo, ce, cp);
            tests++;
            if ({out_valid, busy, out_valid_s, busy_s} !== {ev, pkt.size() > 0, ev, pkt.size() > 0}) begin
                fails++;
                $display("FAIL rand_ctrl_%0d: got v=%b busy=%b vs=%b busys=%b want v=%b busy=%b",
                         cyc, out_valid, busy, out_valid_s, busy_s, ev, pkt.size() > 0);
            end
            if (ev) begin
                tests++;
                if ({out_parity, out_err, beat_cnt, cnt_sat, out_parity_s, out_err_s, beat_cnt_s, cnt_sat_s} !==
                    {ep, ee, 8'((n > 255) ? 255 : n), (n >= 255), ep, ee, 2'((n > 3) ? 3 : n), (n >= 3)}) begin
                    fails++;
                    $display("FAIL rand_pkt_%0d: got p=%b e=%b cnt=%0d sat=%b ps=%b es=%b cnts=%0d sats=%b want p=%b e=%b beats=%0d",
                             cyc, out_parity, out_err, beat_cnt, cnt_sat, out_parity_s, out_err_s,
                             beat_cnt_s, cnt_sat_s, ep, ee, n);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_exhaustive_single();
        test_multi_gap();
        test_odd_check();
        test_back_to_back();
        test_reset_mid_packet();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
